// File: rtl/cdb_broadcast_pkg.sv
// Shared types for the complete stage: result packets coming from the FUs
// and the packet broadcast on the Common Data Bus.
package cdb_broadcast_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
    } FU_RESULT_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
    } CDB_PACKET;

endpackage

// File: rtl/result_fifo.sv
// Small per-FU result buffer with flush. Pointers wrap naturally, so DEPTH
// must be a power of two.
module result_fifo
    import cdb_broadcast_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  FU_RESULT_PACKET push_data,
    input  logic            pop,
    output logic            empty,
    output logic            full,
    output FU_RESULT_PACKET head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    FU_RESULT_PACKET  mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Flush wins over both push and pop; ready is derived from full alone.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cdb_broadcast.sv
// Complete stage: buffers FU results and broadcasts at most one per cycle on
// the registered CDB, granting FIFO heads round-robin.
module cdb_broadcast
    import cdb_broadcast_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             squash,
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value,
    input  logic [NUM_FU-1:0]                fu_take_branch,
    output logic [NUM_FU-1:0]                fu_ready,
    output CDB_PACKET                        cdb_packet_out
);

    localparam int IDX_W = $clog2(NUM_FU);

    // Handshake: a result transfers on a rising edge where fu_valid[i] and
    // fu_ready[i] are both high; the FU holds its data until then. fu_ready
    // comes only from registered FIFO occupancy.
    logic [NUM_FU-1:0] fifo_empty, fifo_full, fifo_pop;
    FU_RESULT_PACKET   push_pkt  [NUM_FU];
    FU_RESULT_PACKET   fifo_head [NUM_FU];

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
    logic             grant_valid;
    CDB_PACKET        cdb_q, cdb_d;
    int               cand;

    assign fu_ready       = ~fifo_full;
    assign cdb_packet_out = cdb_q;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        assign push_pkt[gi].rob_tag     = fu_rob_tag[gi];
        assign push_pkt[gi].value       = fu_value[gi];
        assign push_pkt[gi].take_branch = fu_take_branch[gi];

        result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (fu_valid[gi] & fu_ready[gi]),
            .push_data (push_pkt[gi]),
            .pop       (fifo_pop[gi]),
            .empty     (fifo_empty[gi]),
            .full      (fifo_full[gi]),
            .head      (fifo_head[gi])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_FU;
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        fifo_pop    = '0;
        rr_ptr_d    = rr_ptr_q;
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        if (!squash && grant_valid) begin
            fifo_pop[grant_idx] = 1'b1;
            cdb_d.valid         = 1'b1;
            cdb_d.rob_tag       = fifo_head[grant_idx].rob_tag;
            cdb_d.value         = fifo_head[grant_idx].value;
            cdb_d.take_branch   = fifo_head[grant_idx].take_branch;
            rr_ptr_d = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Bench for cdb_broadcast: per-FU scripted drivers, a queue-level model of
// buffering and round-robin broadcast, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_cdb_broadcast;
    import cdb_broadcast_pkg::*;

    localparam int NUM_FU     = 4;
    localparam int FIFO_DEPTH = 2;

    logic                             clock = 1'b0;
    logic                             reset = 1'b0;
    logic                             squash = 1'b0;
    logic [NUM_FU-1:0]                fu_valid = '0;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_tag = '0;
    logic [NUM_FU-1:0][XLEN-1:0]      fu_value = '0;
    logic [NUM_FU-1:0]                fu_take_branch = '0;
    logic [NUM_FU-1:0]                fu_ready;
    CDB_PACKET                        cdb_packet_out;

    cdb_broadcast #(.NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .fu_valid       (fu_valid),
        .fu_rob_tag     (fu_rob_tag),
        .fu_value       (fu_value),
        .fu_take_branch (fu_take_branch),
        .fu_ready       (fu_ready),
        .cdb_packet_out (cdb_packet_out)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-FU scripts (written by main only) and driver progress (engine only).
    FU_RESULT_PACKET stim_q [NUM_FU][$];
    int              sent   [NUM_FU];
    logic [NUM_FU-1:0] took = '0;

    // Model state: expected FIFO contents, rr pointer and output packet.
    FU_RESULT_PACKET exp_q [NUM_FU][$];
    int              m_rr = 0;
    CDB_PACKET       exp_pkt = '0;

    // Tags seen on the bus, in order.
    logic [ROB_IDX_W-1:0] bc_q[$];
    int                   bc_base = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push(input int fu, input int tag, input logic [XLEN-1:0] val, input logic br);
        FU_RESULT_PACKET e;
        e.rob_tag     = ROB_IDX_W'(tag);
        e.value       = val;
        e.take_branch = br;
        stim_q[fu].push_back(e);
    endtask

    function automatic int bc_count();
        return bc_q.size() - bc_base;
    endfunction

    function automatic int bc_at(input int k);
        return int'(bc_q[bc_base + k]);
    endfunction

    function automatic bit busy();
        for (int i = 0; i < NUM_FU; i++)
            if (sent[i] < stim_q[i].size() || exp_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (busy() && n < max_cycles) begin
            cyc();
            n++;
        end
        check("drain_timeout", 64'(busy()), 64'd0);
        cyc(2);
    endtask

    task automatic reset_seq();
        reset  = 1'b0;
        squash = 1'b0;
        for (int i = 0; i < NUM_FU; i++) stim_q[i].delete();
        cyc(2);
        reset   = 1'b1;
        bc_base = bc_q.size();
    endtask

    // ---------------- driver engine ----------------
    initial begin
        for (int i = 0; i < NUM_FU; i++) sent[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NUM_FU; i++) begin
                if (!reset)       sent[i] = 0;
                else if (took[i]) sent[i]++;
                if (sent[i] < stim_q[i].size()) begin
                    fu_valid[i]       = 1'b1;
                    fu_rob_tag[i]     = stim_q[i][sent[i]].rob_tag;
                    fu_value[i]       = stim_q[i][sent[i]].value;
                    fu_take_branch[i] = stim_q[i][sent[i]].take_branch;
                end else begin
                    fu_valid[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    initial begin
        int g;
        int j;
        logic [NUM_FU-1:0] rdy;
        FU_RESULT_PACKET e;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                for (int i = 0; i < NUM_FU; i++) exp_q[i].delete();
                took    = '0;
                m_rr    = 0;
                exp_pkt = '0;
            end else begin
                for (int i = 0; i < NUM_FU; i++) rdy[i] = (exp_q[i].size() < FIFO_DEPTH);
                took          = fu_valid & rdy;
                exp_pkt.valid = 1'b0;
                if (squash) begin
                    for (int i = 0; i < NUM_FU; i++) exp_q[i].delete();
                end else begin
                    g = -1;
                    for (int k = 0; k < NUM_FU; k++) begin
                        j = (m_rr + k) % NUM_FU;
                        if (g < 0 && exp_q[j].size() != 0) g = j;
                    end
                    if (g >= 0) begin
                        e = exp_q[g].pop_front();
                        exp_pkt.valid       = 1'b1;
                        exp_pkt.rob_tag     = e.rob_tag;
                        exp_pkt.value       = e.value;
                        exp_pkt.take_branch = e.take_branch;
                        m_rr = (g + 1) % NUM_FU;
                    end
                    for (int i = 0; i < NUM_FU; i++) begin
                        if (took[i]) begin
                            e.rob_tag     = fu_rob_tag[i];
                            e.value       = fu_value[i];
                            e.take_branch = fu_take_branch[i];
                            exp_q[i].push_back(e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NUM_FU-1:0] exp_rdy;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = (exp_q[i].size() < FIFO_DEPTH);
            check("cdb_packet", 64'(cdb_packet_out), 64'(exp_pkt));
            check("fu_ready", 64'(fu_ready), 64'(exp_rdy));
            if (cdb_packet_out.valid) bc_q.push_back(cdb_packet_out.rob_tag);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- directed + random sequences ----------------
    initial begin
        int tagc;
        int rate;
        cyc(2);
        reset = 1'b1;
        cyc();
        check("reset_pkt", 64'(cdb_packet_out), 64'd0);
        check("reset_ready", 64'(fu_ready), 64'hF);

        // Single result: accepted at edge 1, on the bus after edge 2 only.
        reset_seq();
        push(2, 5, 32'hDEAD, 1'b0);
        cyc();
        check("single_early", 64'(cdb_packet_out.valid), 64'd0);
        cyc();
        check("single_valid", 64'(cdb_packet_out.valid), 64'd1);
        check("single_tag", 64'(cdb_packet_out.rob_tag), 64'd5);
        check("single_value", 64'(cdb_packet_out.value), 64'hDEAD);
        cyc();
        check("single_after", 64'(cdb_packet_out.valid), 64'd0);

        // Contention: four pushes together broadcast back to back in FU order.
        reset_seq();
        for (int i = 0; i < NUM_FU; i++) push(i, 10 + i, 32'(100 + i), 1'(i));
        cyc();
        for (int k = 0; k < NUM_FU; k++) begin
            cyc();
            check("contend_slot", 64'({cdb_packet_out.valid, cdb_packet_out.rob_tag}),
                  64'({1'b1, 5'(10 + k)}));
        end
        drain(50);

        // Fairness: FU0 even tags, FU3 odd tags, strictly alternating.
        reset_seq();
        for (int k = 0; k < 6; k++) begin
            push(0, 2 * k, 32'(k), 1'b0);
            push(3, 2 * k + 1, 32'(k), 1'b1);
        end
        drain(100);
        check("fair_count", 64'(bc_count()), 64'd12);
        for (int k = 0; k < 12 && k < bc_count(); k++) check("fair_order", 64'(bc_at(k)), 64'(k));

        // Full FIFO: FU1 fills behind FU0 and its third result waits.
        reset_seq();
        for (int k = 0; k < 6; k++) push(0, 40 + k, 32'(k), 1'b0);
        for (int k = 0; k < 3; k++) push(1, 20 + k, 32'(k + 7), 1'b1);
        cyc(2);
        check("full_ready", 64'(fu_ready), 64'b1101);
        cyc();
        check("full_reopen", 64'(fu_ready), 64'b1110);
        check("full_first_fu1", 64'(cdb_packet_out.rob_tag), 64'd20);
        drain(100);
        check("full_count", 64'(bc_count()), 64'd9);
        begin
            int want;
            want = 20;
            for (int k = 0; k < bc_count(); k++) begin
                if (bc_at(k) >= 20 && bc_at(k) <= 22) begin
                    check("full_fu1_order", 64'(bc_at(k)), 64'(want));
                    want++;
                end
            end
            check("full_fu1_all", 64'(want), 64'd23);
        end

        // Squash with two buffered results and a concurrent push on FU0.
        reset_seq();
        push(1, 14, 32'h1, 1'b0);
        push(2, 15, 32'h2, 1'b0);
        cyc();
        squash = 1'b1;
        push(0, 30, 32'h3, 1'b0);
        cyc();
        squash = 1'b0;
        check("squash_valid", 64'(cdb_packet_out.valid), 64'd0);
        check("squash_ready", 64'(fu_ready), 64'hF);
        cyc(5);
        check("squash_no_bcast", 64'(bc_count()), 64'd0);

        // Async reset while a broadcast is on the bus.
        reset_seq();
        push(2, 3, 32'h1234, 1'b1);
        cyc(2);
        check("mid_valid", 64'(cdb_packet_out.valid), 64'd1);
        #1 reset = 1'b0;
        #1 check("mid_async_zero", 64'(cdb_packet_out), 64'd0);
        reset_seq();
        check("mid_ready", 64'(fu_ready), 64'hF);
        push(3, 8, 32'h8, 1'b0);
        push(0, 7, 32'h7, 1'b0);
        drain(50);
        check("mid_count", 64'(bc_count()), 64'd2);
        if (bc_count() == 2) begin
            check("mid_first", 64'(bc_at(0)), 64'd7);
            check("mid_second", 64'(bc_at(1)), 64'd8);
        end

        // Random traffic with occasional squashes.
        reset_seq();
        tagc = 0;
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 40 : 15;
            for (int i = 0; i < NUM_FU; i++) begin
                if ($urandom_range(0, 99) < rate && stim_q[i].size() - sent[i] < 2) begin
                    push(i, tagc, $urandom, 1'($urandom_range(0, 1)));
                    tagc = (tagc + 1) % 32;
                end
            end
            squash = ($urandom_range(0, 79) == 0);
            cyc();
        end
        squash = 1'b0;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
